// File: rtl/rvfi_trace_buffer.sv
// Retirement trace buffer: filters RVFI retirements into a show-ahead FIFO
// drained over valid/ready, with retirement and overflow-drop statistics.
module rvfi_trace_buffer #(
   parameter int DEPTH          = 16,
   parameter bit FILTER_BOOTROM = 1'b1,
   parameter int DROP_CNT_W     = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     flush,
   input  logic                     rvfi_valid,
   input  logic [31:0]              rvfi_pc_rdata,
   input  logic [31:0]              rvfi_insn,
   input  logic [4:0]               rvfi_rd_addr,
   input  logic [31:0]              rvfi_rd_wdata,
   output logic                     trace_valid,
   input  logic                     trace_ready,
   output logic [31:0]              trace_pc,
   output logic [31:0]              trace_insn,
   output logic [4:0]               trace_rd_addr,
   output logic [31:0]              trace_rd_wdata,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [31:0]              retire_count,
   output logic [DROP_CNT_W-1:0]    drop_count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
   } rec_t;

   rec_t                  mem_r [DEPTH];
   logic [AW:0]           wr_ptr_r;
   logic [AW:0]           rd_ptr_r;
   logic [AW:0]           level_r;
   logic [31:0]           retire_count_r;
   logic [DROP_CNT_W-1:0] drop_count_r;
   logic                  overflow_r;

   logic                  bootrom_s;
   logic                  acc_s;
   logic                  empty_s;
   logic                  full_s;
   logic                  pop_s;
   logic                  push_s;
   logic                  drop_s;
   rec_t                  wr_rec_s;
   rec_t                  head_s;

   assign bootrom_s = FILTER_BOOTROM && (&rvfi_pc_rdata[31:12]);
   assign acc_s     = rvfi_valid & enable & ~bootrom_s;
   assign empty_s   = (wr_ptr_r == rd_ptr_r);
   assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign pop_s     = ~empty_s & trace_ready;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts.
   assign push_s    = acc_s & (~full_s | pop_s);
   assign drop_s    = acc_s & full_s & ~pop_s;

   assign wr_rec_s.pc       = rvfi_pc_rdata;
   assign wr_rec_s.insn     = rvfi_insn;
   assign wr_rec_s.rd_addr  = rvfi_rd_addr;
   assign wr_rec_s.rd_wdata = (rvfi_rd_addr == 5'd0) ? 32'd0 : rvfi_rd_wdata;

   assign head_s = mem_r[rd_ptr_r[AW-1:0]];

   // Record storage; contents are don't-care until covered by the pointers.
   always_ff @(posedge clk) begin
      if (push_s && !flush) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wr_rec_s;
      end
   end

   // Pointers, occupancy and drop statistics; flush overrides push and pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r     <= {(AW+1){1'b0}};
         rd_ptr_r     <= {(AW+1){1'b0}};
         level_r      <= {(AW+1){1'b0}};
         drop_count_r <= {DROP_CNT_W{1'b0}};
         overflow_r   <= 1'b0;
      end else if (flush) begin
         wr_ptr_r     <= {(AW+1){1'b0}};
         rd_ptr_r     <= {(AW+1){1'b0}};
         level_r      <= {(AW+1){1'b0}};
         drop_count_r <= {DROP_CNT_W{1'b0}};
         overflow_r   <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + {{AW{1'b0}}, 1'b1};
            2'b01:   level_r <= level_r - {{AW{1'b0}}, 1'b1};
            default: level_r <= level_r;
         endcase
         if (drop_s) begin
            overflow_r <= 1'b1;
            if (!(&drop_count_r)) begin
               drop_count_r <= drop_count_r + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   // Retirement counter counts filtered retirements regardless of flush or drops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         retire_count_r <= 32'd0;
      end else if (acc_s) begin
         retire_count_r <= retire_count_r + 32'd1;
      end else begin
         retire_count_r <= retire_count_r;
      end
   end

   // Head presentation; gated to zero while empty so reset/flush clear outputs.
   always_comb begin
      trace_valid    = ~empty_s;
      trace_pc       = 32'd0;
      trace_insn     = 32'd0;
      trace_rd_addr  = 5'd0;
      trace_rd_wdata = 32'd0;
      if (!empty_s) begin
         trace_pc       = head_s.pc;
         trace_insn     = head_s.insn;
         trace_rd_addr  = head_s.rd_addr;
         trace_rd_wdata = head_s.rd_wdata;
      end else begin
         trace_pc       = 32'd0;
      end
   end

   assign fifo_level   = level_r;
   assign retire_count = retire_count_r;
   assign drop_count   = drop_count_r;
   assign overflow     = overflow_r;

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Bench for rvfi_trace_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rvfi_trace_buffer;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        flush;
   logic        rvfi_valid;
   logic [31:0] rvfi_pc_rdata;
   logic [31:0] rvfi_insn;
   logic [4:0]  rvfi_rd_addr;
   logic [31:0] rvfi_rd_wdata;
   logic        trace_valid;
   logic        trace_ready;
   logic [31:0] trace_pc;
   logic [31:0] trace_insn;
   logic [4:0]  trace_rd_addr;
   logic [31:0] trace_rd_wdata;
   logic [4:0]  fifo_level;
   logic [31:0] retire_count;
   logic [15:0] drop_count;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [4:0]  rd;
      logic [31:0] wd;
   } rec_t;

   rec_t        q[$];
   logic [31:0] m_ret;
   int          m_drop;
   bit          m_ovf;

   rvfi_trace_buffer #(.DEPTH(DEPTH), .FILTER_BOOTROM(1'b1), .DROP_CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
      .rvfi_valid(rvfi_valid), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn),
      .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
      .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
      .trace_insn(trace_insn), .trace_rd_addr(trace_rd_addr), .trace_rd_wdata(trace_rd_wdata),
      .fifo_level(fifo_level), .retire_count(retire_count), .drop_count(drop_count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of records, updated on each clock edge or reset.
   initial begin
      bit   acc;
      bit   pop;
      rec_t r;
      m_ret  = 32'd0;
      m_drop = 0;
      m_ovf  = 1'b0;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            q.delete();
            m_ret  = 32'd0;
            m_drop = 0;
            m_ovf  = 1'b0;
         end else begin
            acc = rvfi_valid && enable && (rvfi_pc_rdata[31:12] != 20'hFFFFF);
            pop = (q.size() > 0) && trace_ready;
            if (acc) m_ret = m_ret + 32'd1;
            if (flush) begin
               q.delete();
               m_drop = 0;
               m_ovf  = 1'b0;
            end else begin
               if (pop) void'(q.pop_front());
               if (acc) begin
                  if (q.size() < DEPTH) begin
                     r.pc   = rvfi_pc_rdata;
                     r.insn = rvfi_insn;
                     r.rd   = rvfi_rd_addr;
                     r.wd   = (rvfi_rd_addr == 5'd0) ? 32'd0 : rvfi_rd_wdata;
                     q.push_back(r);
                  end else begin
                     if (m_drop < 65535) m_drop++;
                     m_ovf = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("trace_valid", trace_valid, q.size() != 0);
         if (q.size() != 0) begin
            chk("trace_pc", trace_pc, q[0].pc);
            chk("trace_insn", trace_insn, q[0].insn);
            chk("trace_rd_addr", trace_rd_addr, q[0].rd);
            chk("trace_rd_wdata", trace_rd_wdata, q[0].wd);
         end else begin
            chk("trace_pc_idle", trace_pc, 32'd0);
            chk("trace_wdata_idle", trace_rd_wdata, 32'd0);
         end
         chk("fifo_level", fifo_level, q.size());
         chk("retire_count", retire_count, m_ret);
         chk("drop_count", drop_count, m_drop);
         chk("overflow", overflow, m_ovf);
      end
   end

   task automatic cyc(input bit v, input logic [31:0] p, input logic [4:0] r,
                      input logic [31:0] w, input bit rdy);
      rvfi_valid    = v;
      rvfi_pc_rdata = p;
      rvfi_insn     = p ^ 32'h0000_0013;
      rvfi_rd_addr  = r;
      rvfi_rd_wdata = w;
      trace_ready   = rdy;
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b1;
      enable = 1'b1; flush = 1'b0; rvfi_valid = 1'b0; trace_ready = 1'b0;
      rvfi_pc_rdata = 32'd0; rvfi_insn = 32'd0; rvfi_rd_addr = 5'd0; rvfi_rd_wdata = 32'd0;
      #1 reset_n = 1'b0;
      @(negedge clk);
      chk("rst_valid", trace_valid, 1'b0);
      chk("rst_level", fifo_level, 5'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Three back-to-back retirements drained immediately.
      cyc(1'b1, 32'h0, 5'd1, 32'h11, 1'b1);
      chk("t1_first_visible", trace_pc, 32'h0);
      chk("t1_valid_n1", trace_valid, 1'b1);
      cyc(1'b1, 32'h4, 5'd2, 32'h22, 1'b1);
      chk("t1_second", trace_pc, 32'h4);
      cyc(1'b1, 32'h8, 5'd3, 32'h33, 1'b1);
      chk("t1_third", trace_pc, 32'h8);
      for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 5'd0, 32'h0, 1'b1);
      chk("t1_retire", retire_count, 32'd3);
      chk("t1_level", fifo_level, 5'd0);

      // Boot-ROM filter.
      cyc(1'b1, 32'hFFFF_F010, 5'd4, 32'h44, 1'b0);
      chk("t2_filtered_retire", retire_count, 32'd3);
      chk("t2_filtered_valid", trace_valid, 1'b0);
      cyc(1'b1, 32'h0000_1010, 5'd3, 32'h55, 1'b0);
      chk("t2_pass_retire", retire_count, 32'd4);
      chk("t2_pass_pc", trace_pc, 32'h0000_1010);
      chk("t2_pass_wdata", trace_rd_wdata, 32'h55);
      cyc(1'b0, 32'h0, 5'd0, 32'h0, 1'b1);

      // Overflow: 20 retirements with no drain.
      for (int i = 0; i < 20; i++) cyc(1'b1, 32'h100 + 32'(4*i), 5'd5, 32'(i), 1'b0);
      chk("t3_level", fifo_level, 5'd16);
      chk("t3_drop", drop_count, 16'd4);
      chk("t3_ovf", overflow, 1'b1);
      chk("t3_retire", retire_count, 32'd24);
      chk("t3_head", trace_pc, 32'h100);

      // Full FIFO with simultaneous push and pop.
      cyc(1'b1, 32'h900, 5'd6, 32'h66, 1'b1);
      chk("t4_level", fifo_level, 5'd16);
      chk("t4_drop", drop_count, 16'd4);
      chk("t4_head", trace_pc, 32'h104);
      for (int i = 1; i < 16; i++) begin
         chk("t4_drain_pc", trace_pc, 32'h100 + 32'(4*i));
         cyc(1'b0, 32'h0, 5'd0, 32'h0, 1'b1);
      end
      chk("t4_tail_pc", trace_pc, 32'h900);
      cyc(1'b0, 32'h0, 5'd0, 32'h0, 1'b1);
      chk("t4_empty", trace_valid, 1'b0);

      // rd==0 forces write data to zero; then flush with concurrent retirement.
      cyc(1'b1, 32'h2000, 5'd0, 32'hDEAD_BEEF, 1'b0);
      chk("t5_rd0_wdata", trace_rd_wdata, 32'd0);
      for (int i = 1; i < 5; i++) cyc(1'b1, 32'h2000 + 32'(4*i), 5'd7, 32'hDEAD_BEEF, 1'b0);
      chk("t5_level5", fifo_level, 5'd5);
      flush = 1'b1;
      cyc(1'b1, 32'h3000, 5'd8, 32'h77, 1'b1);
      flush = 1'b0;
      chk("t5_flush_level", fifo_level, 5'd0);
      chk("t5_flush_drop", drop_count, 16'd0);
      chk("t5_flush_ovf", overflow, 1'b0);
      chk("t5_flush_retire", retire_count, 32'd31);

      // Disabled capture blocks new pushes.
      enable = 1'b0;
      cyc(1'b1, 32'h4000, 5'd9, 32'h88, 1'b0);
      chk("t6_disabled_retire", retire_count, 32'd31);
      chk("t6_disabled_level", fifo_level, 5'd0);
      enable = 1'b1;

      // Asynchronous reset mid-drain.
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'h5000 + 32'(4*i), 5'd10, 32'h99, 1'b0);
      chk("t7_level4", fifo_level, 5'd4);
      #3 reset_n = 1'b0;
      #1;
      chk("t7_async_valid", trace_valid, 1'b0);
      chk("t7_async_level", fifo_level, 5'd0);
      chk("t7_async_retire", retire_count, 32'd0);
      chk("t7_async_pc", trace_pc, 32'd0);
      chk("t7_async_drop", drop_count, 16'd0);
      @(negedge clk);
      reset_n = 1'b1;
      cyc(1'b0, 32'h0, 5'd0, 32'h0, 1'b1);
      cyc(1'b0, 32'h0, 5'd0, 32'h0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
